sipo_2to8: RTL and testbench
============================

Name: sipo_2to8

Overview:
- Downstream companion to the 8-to-2 serializer. Collects consecutive 2-bit valid/ready beats and reassembles them into 8-bit words, then presents each word on a valid/ready output.
- Sits at the receive side of the narrow link and restores the original byte stream.
- One output holding register lets a new word assemble while the previous word waits for a consumer, so the block sustains one beat per cycle.

Parameters:
- IN_W, 2, width of the input beat; must divide OUT_W.
- OUT_W, 8, width of the output word.
- BEATS, OUT_W/IN_W (derived localparam, 4), beats per word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  interface  valid_ready_std_if #(.DATAWIDTH(IN_W)), modport in  narrow input stream.
  - din.data  in  IN_W  beat payload.
  - din.valid  in  1  beat present.
  - din.ready  out  1  block accepts the beat.
- dout  interface  valid_ready_std_if #(.DATAWIDTH(OUT_W)), modport out  word output stream.
  - dout.data  out  OUT_W  assembled word.
  - dout.valid  out  1  word present.
  - dout.ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, acc=0, dout.valid=0, dout.data=0.
  - din.ready is combinational and reads 1 while in reset.
- Handshakes:
  - Input beat transfer: din.valid & din.ready at a rising edge.
  - Output word transfer: dout.valid & dout.ready at a rising edge.
- Beat order is MSB-first by default:
  - Beat k (k=0..BEATS-1) lands in bits [OUT_W-1-k*IN_W -: IN_W].
  - The accumulator shifts left by IN_W and the new beat enters the low bits.
- Counter cnt (0..BEATS-1):
  - Increments on each input transfer.
  - Wraps to 0 on the transfer where cnt==BEATS-1 (the last beat).
- Last-beat transfer:
  - dout.data <= {acc[OUT_W-IN_W-1:0], din.data}; dout.valid <= 1 on the same edge.
  - Latency: word valid 1 cycle after its last beat is accepted.
- din.ready = (cnt != BEATS-1) | ~dout.valid | dout.ready.
  - Non-last beats are always accepted, even while an output word is pending.
  - The last beat stalls only while the holding register is full and not draining.
- dout.valid:
  - Clears on an output transfer, unless a new last beat is accepted on the same edge.
  - In that case it stays 1 and the data is replaced; this gives back-to-back words at full rate.
- dout.data and dout.valid hold stable while dout.valid=1 and dout.ready=0 (AXI-style stability).
- din.valid low mid-word: cnt and acc hold; there is no timeout.
- din.data is ignored when din.valid=0.
- Reset mid-word: the partial word is discarded, and any pending output word is dropped (dout.valid=0).
- No combinational path from din.valid or din.data to dout.*. The only combinational path is dout.ready -> din.ready.
- Throughput: 1 beat/cycle sustained when dout.ready=1.

Optional Feature:
- Macro: SIPO_LSB_FIRST_EN.
- Defined:
  - Beat k lands in bits [k*IN_W +: IN_W]; the accumulator shifts right and the new beat enters the high bits.
  - Beats 01,11,00,11 then produce 8'hCD.
- Undefined: MSB-first ordering as in Behaviour.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-operation (cnt=2, dout.valid=1) -> dout.valid=0 immediately, cnt=0; the next 4 beats form a fresh word.
- Single word: dout.ready=1; beats 2'b11,2'b00,2'b11,2'b01 on 4 consecutive cycles -> dout.valid=1 with data 8'hCD in the cycle after the 4th beat, for 1 cycle.
- Backpressure: dout.ready=0; send 8'hCD beats then 8'h27 beats (00,10,01,11):
  - First 3 beats of the second word are accepted; din.ready=0 at the 4th.
  - dout.data holds 8'hCD while ready stays low.
  - Raise dout.ready -> 8'hCD transfers, the 4th beat is accepted the same edge, 8'h27 appears the next cycle.
- Full rate: 16 back-to-back beats with dout.ready=1 -> 4 words on cycles 5,9,13,17 after the first beat, no din.ready deassertion.
- Input gaps: din.valid toggled 1/0 every cycle while sending 8'hA5 -> a single 8'hA5 word, and data on invalid cycles does not corrupt it.
- Optional-feature check: built with SIPO_LSB_FIRST_EN, beats 01,11,00,11 -> 8'hCD; without the macro, the same beats -> 8'h73.

Source files
------------

// File: rtl/valid_ready_std_if.sv
`default_nettype none
// ============================================================================
// Module   : valid_ready_std_if
// Purpose  : Generic valid/ready stream bundle with a parameterised payload.
// Modports : master / out - source side (drives data, valid; samples ready)
//            slave  / in  - sink side   (samples data, valid; drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface valid_ready_std_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
  modport out    (output data, output valid, input  ready);
  modport in     (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/sipo_2to8.sv
`default_nettype none
// ============================================================================
// Module   : sipo_2to8
// Purpose  : Reassembles consecutive IN_W-bit valid/ready beats into OUT_W-bit
//            words and presents them on a valid/ready output with one holding
//            register, sustaining one beat per cycle.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset (synchronous release)
//            din   - narrow input stream  (valid_ready_std_if, modport in)
//            dout  - word output stream   (valid_ready_std_if, modport out)
// Options  : SIPO_LSB_FIRST_EN - when defined, beat k lands in bits
//            [k*IN_W +: IN_W]; otherwise beats are MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_2to8 #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8
) (
  input  wire             clk,
  input  wire             rst_n,
  valid_ready_std_if.in   din,
  valid_ready_std_if.out  dout
);

  localparam int BEATS = OUT_W / IN_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BEATS - 1);

  // Only the OUT_W-IN_W bits that survive into the next word are stored;
  // the final beat is merged straight into the output register.
  logic [CW-1:0]         r_cnt;
  logic [OUT_W-IN_W-1:0] r_acc;
  logic [OUT_W-1:0]      r_dout_data;
  logic                  r_dout_valid;

  logic                  w_last;
  logic                  w_ready;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic [OUT_W-1:0]      w_word;
  logic [OUT_W-IN_W-1:0] w_acc_next;

  assign w_last = (r_cnt == C_LAST);

  // Non-last beats never stall; the last beat needs a free or draining
  // holding register. dout.ready -> din.ready is the only comb path.
  assign w_ready    = ~w_last | ~r_dout_valid | dout.ready;
  assign w_in_xfer  = din.valid & w_ready;
  assign w_out_xfer = r_dout_valid & dout.ready;

`ifdef SIPO_LSB_FIRST_EN
  // Shift right; the newest beat enters at the top.
  assign w_word     = {din.data, r_acc};
  assign w_acc_next = w_word[OUT_W-1:IN_W];
`else
  // Shift left; the newest beat enters at the bottom.
  assign w_word     = {r_acc, din.data};
  assign w_acc_next = w_word[OUT_W-IN_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_dout_data  <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_acc <= w_acc_next;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
      // A new word on the draining edge keeps valid high for back-to-back words.
      if (w_in_xfer && w_last) begin
        r_dout_data  <= w_word;
        r_dout_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign din.ready  = w_ready;
  assign dout.data  = r_dout_data;
  assign dout.valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_sipo_2to8.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_2to8
// Purpose  : Self-checking bench for sipo_2to8 with a transaction-level
//            reference model (beat queue -> word by positional arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_2to8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 8;
  localparam int BEATS = OUT_W / IN_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  valid_ready_std_if #(.DATAWIDTH(IN_W))  din_if ();
  valid_ready_std_if #(.DATAWIDTH(OUT_W)) dout_if ();

  sipo_2to8 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din_if),
    .dout  (dout_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats collected so far, plus the word awaiting a consumer.
  logic [IN_W-1:0]  m_beats[$];
  logic             m_pend;
  logic [OUT_W-1:0] m_word;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] assemble();
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < BEATS; k++) begin
`ifdef SIPO_LSB_FIRST_EN
      w = w | (OUT_W'(m_beats[k]) << (k * IN_W));
`else
      w = w | (OUT_W'(m_beats[k]) << (OUT_W - (k + 1) * IN_W));
`endif
    end
    return w;
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_pend = 1'b0;
    m_word = '0;
  endtask

  // One clock: drive, check pre-edge outputs, advance model on the edge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic r, output logic acc);
    logic exp_rdy;
    din_if.valid  = v;
    din_if.data   = d;
    dout_if.ready = r;
    #1;
    exp_rdy = !((m_beats.size() == BEATS - 1) && m_pend && !r);
    check("din_ready",  OUT_W'(din_if.ready),  OUT_W'(exp_rdy));
    check("dout_valid", OUT_W'(dout_if.valid), OUT_W'(m_pend));
    if (m_pend) check("dout_data", dout_if.data, m_word);
    @(posedge clk);
    acc = v & exp_rdy;
    if (m_pend && r) m_pend = 1'b0;
    if (acc) begin
      m_beats.push_back(d);
      if (m_beats.size() == BEATS) begin
        m_word = assemble();
        m_pend = 1'b1;
        m_beats.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic r);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) cycle(1'b1, d, r, acc);
    check("send_timeout", OUT_W'(acc), OUT_W'(1));
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, IN_W'($urandom), r, acc);
  endtask

  initial begin
    logic acc;
    logic [OUT_W-1:0] c_exp;
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    model_reset();

    // Reset state
    #3;
    check("rst_ready", OUT_W'(din_if.ready),  OUT_W'(1));
    check("rst_valid", OUT_W'(dout_if.valid), OUT_W'(0));
    check("rst_data",  dout_if.data,          8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, consumer ready
    send_beat(2'b11, 1'b1);
    send_beat(2'b00, 1'b1);
    send_beat(2'b11, 1'b1);
    send_beat(2'b01, 1'b1);
    idle(3, 1'b1);

    // Beat ordering against fixed values for the built configuration
`ifdef SIPO_LSB_FIRST_EN
    c_exp = 8'hCD;
`else
    c_exp = 8'h73;
`endif
    send_beat(2'b01, 1'b1);
    send_beat(2'b11, 1'b1);
    send_beat(2'b00, 1'b1);
    send_beat(2'b11, 1'b1);
    #1;
    check("order_word", dout_if.data, c_exp);
    idle(2, 1'b1);

    // Backpressure: first word parks, 3 beats of the second accepted, 4th stalls
    send_beat(2'b11, 1'b0);
    send_beat(2'b00, 1'b0);
    send_beat(2'b11, 1'b0);
    send_beat(2'b01, 1'b0);
    send_beat(2'b00, 1'b0);
    send_beat(2'b10, 1'b0);
    send_beat(2'b01, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, acc);
    check("bp_stall", OUT_W'(acc), OUT_W'(0));
    cycle(1'b1, 2'b11, 1'b0, acc);
    cycle(1'b1, 2'b11, 1'b1, acc);
    check("bp_release", OUT_W'(acc), OUT_W'(1));
    #1;
    check("bp_valid2", OUT_W'(dout_if.valid), OUT_W'(1));
    idle(3, 1'b1);

    // Full rate: 16 back-to-back beats, din.ready must never drop
    for (int i = 0; i < 4 * BEATS; i++) begin
      cycle(1'b1, IN_W'($urandom), 1'b1, acc);
      check("fullrate_acc", OUT_W'(acc), OUT_W'(1));
    end
    idle(3, 1'b1);

    // Input gaps with garbage on invalid cycles (8'hA5 MSB-first beats)
    cycle(1'b1, 2'b10, 1'b1, acc); cycle(1'b0, 2'b01, 1'b1, acc);
    cycle(1'b1, 2'b10, 1'b1, acc); cycle(1'b0, 2'b11, 1'b1, acc);
    cycle(1'b1, 2'b01, 1'b1, acc); cycle(1'b0, 2'b10, 1'b1, acc);
    cycle(1'b1, 2'b01, 1'b1, acc); cycle(1'b0, 2'b00, 1'b1, acc);
    idle(3, 1'b1);

    // Reset mid-operation: word pending and two beats of the next collected
    for (int i = 0; i < BEATS + 2; i++) send_beat(IN_W'($urandom), 1'b0);
    check("pre_rst_valid", OUT_W'(dout_if.valid), OUT_W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", OUT_W'(dout_if.valid), OUT_W'(0));
    check("mid_rst_ready", OUT_W'(din_if.ready),  OUT_W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_beat(2'b10, 1'b1);
    send_beat(2'b10, 1'b1);
    send_beat(2'b01, 1'b1);
    send_beat(2'b01, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), IN_W'($urandom), 1'($urandom_range(0, 1)), acc);
    idle(4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
